// File: rtl/seq_mult.sv
// Iterative radix-2 shift-add multiplier with a START/BUSY/DONE handshake.
// Produces the full 2*WIDTH-bit product as HI/LO, in signed or unsigned mode.
// Signed operands are reduced to magnitudes, multiplied unsigned, and the
// product is negated at the end when the operand signs differ.
//
// state  | meaning
// S_IDLE | waiting for start, operands latched on accept
// S_PREP | take magnitudes, record result sign, clear accumulator
// S_CALC | one shift-add step per cycle, WIDTH cycles
// S_FIX  | apply sign, load hi/lo on the edge into S_DONE
// S_DONE | one-cycle done pulse; also accepts a new start
module seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc_hi;
  logic               neg;
  logic               sgn_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_fix;

  // Upper-half add with carry kept; the multiplier register doubles as the
  // low half of the accumulator as it shifts out.
  assign sum         = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : '0);
  assign product     = {acc_hi, mplier};
  assign product_fix = neg ? (~product + 1'b1) : product;

  assign busy = (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; S_DONE accepts a held start so back-to-back
  // operations run at a WIDTH+3 cycle cadence.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_PREP;
      S_PREP:  state_nxt = S_CALC;
      S_CALC:  if (cnt == LAST) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_PREP : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, magnitude preparation and shift-add iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      neg    <= 1'b0;
      sgn_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mcand  <= op1;
            mplier <= op2;
            sgn_q  <= signed_mode;
          end
        end
        S_PREP: begin
          // The most-negative value negates to itself, which is already its
          // correct unsigned magnitude.
          if (sgn_q && mcand[WIDTH-1])  mcand  <= ~mcand + 1'b1;
          if (sgn_q && mplier[WIDTH-1]) mplier <= ~mplier + 1'b1;
          neg    <= sgn_q & (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
          acc_hi <= '0;
          cnt    <= '0;
        end
        S_CALC: begin
          acc_hi <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers hold until the next completion or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX) begin
      hi <= product_fix[2*WIDTH-1:WIDTH];
      lo <= product_fix[WIDTH-1:0];
    end
  end

endmodule
